// File: rtl/ch_packet_scheduler_if.sv
// Bundle of channel FIFO read-side signals and the upstream valid/ready link
// used by ch_packet_scheduler.
interface ch_packet_scheduler_if;
  logic [3:0]        ch_enable;
  logic [3:0][12:0]  ch_rdusedw;
  logic [3:0][63:0]  ch_q;
  logic [3:0]        ch_rdreq;
  logic              up_ready;
  logic              up_valid;
  logic [63:0]       up_data;
  logic              up_sop;
  logic              up_eop;
  logic              busy;
  logic [1:0]        cur_ch;

  modport master (
    input  ch_enable, ch_rdusedw, ch_q, up_ready,
    output ch_rdreq, up_valid, up_data, up_sop, up_eop, busy, cur_ch
  );

  modport slave (
    output ch_enable, ch_rdusedw, ch_q, up_ready,
    input  ch_rdreq, up_valid, up_data, up_sop, up_eop, busy, cur_ch
  );
endinterface

// File: rtl/ch_packet_scheduler.sv
// Round-robin scheduler: drains one full packet at a time from four show-ahead
// channel FIFOs onto a single 64-bit valid/ready link, prefixed by a header word.
module ch_packet_scheduler #(
  parameter int unsigned PKT_LEN   = 128,
  parameter int unsigned SEQ_W     = 16,
  parameter logic [31:0] HDR_MAGIC = 32'hADF90C00
) (
  input  logic                  fifo_rdclk,
  input  logic                  rst_n,
  ch_packet_scheduler_if.master sched_if
);

  localparam logic [12:0] PktLenW  = 13'(PKT_LEN);
  localparam logic [11:0] LastBeat = 12'(PKT_LEN - 1);

  typedef enum logic [1:0] {StIdle, StHead, StPayload} state_e;

  state_e                  r_state, w_state_nxt;
  logic [11:0]             r_beat_cnt, w_beat_cnt_nxt;
  logic [1:0]              r_last_grant, w_last_grant_nxt;
  logic [1:0]              r_cur_ch, w_cur_ch_nxt;
  logic [3:0][SEQ_W-1:0]   r_seq, w_seq_nxt;
  logic                    r_up_valid, w_up_valid_nxt;
  logic                    r_up_sop, w_up_sop_nxt;
  logic                    r_up_eop, w_up_eop_nxt;
  logic [63:0]             r_up_data, w_up_data_nxt;

  logic                    w_accept;
  logic [3:0]              w_elig;
  logic                    w_any_elig;
  logic [1:0]              w_grant;
  logic [1:0]              w_idx;
  logic [3:0]              w_rdreq;

  assign w_accept = !r_up_valid || sched_if.up_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_elig[i] = sched_if.ch_enable[i] && (sched_if.ch_rdusedw[i] >= PktLenW);
    end
  end

  // Search starts just after the last served channel; k == 4 wraps back to it.
  always_comb begin
    w_any_elig = 1'b0;
    w_grant    = r_last_grant;
    w_idx      = r_last_grant;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last_grant + 2'(k);
      if (!w_any_elig && w_elig[w_idx]) begin
        w_any_elig = 1'b1;
        w_grant    = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_last_grant_nxt = r_last_grant;
    w_cur_ch_nxt     = r_cur_ch;
    w_seq_nxt        = r_seq;
    w_up_valid_nxt   = r_up_valid;
    w_up_sop_nxt     = r_up_sop;
    w_up_eop_nxt     = r_up_eop;
    w_up_data_nxt    = r_up_data;
    w_rdreq          = '0;

    // A consumed word drops its qualifiers unless a new word is loaded below.
    if (w_accept) begin
      w_up_valid_nxt = 1'b0;
      w_up_sop_nxt   = 1'b0;
      w_up_eop_nxt   = 1'b0;
    end

    unique case (r_state)
      StIdle: begin
        if (w_any_elig) begin
          w_cur_ch_nxt   = w_grant;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = StHead;
        end
      end
      StHead: begin
        if (w_accept) begin
          w_up_data_nxt  = {HDR_MAGIC, {6'd0, r_cur_ch} + 8'd1, 8'h00, 16'(r_seq[r_cur_ch])};
          w_up_sop_nxt   = 1'b1;
          w_up_valid_nxt = 1'b1;
          w_state_nxt    = StPayload;
        end
      end
      StPayload: begin
        w_rdreq[r_cur_ch] = w_accept;
        if (w_accept) begin
          w_up_data_nxt  = sched_if.ch_q[r_cur_ch];
          w_up_valid_nxt = 1'b1;
          w_beat_cnt_nxt = r_beat_cnt + 12'd1;
          if (r_beat_cnt == LastBeat) begin
            w_up_eop_nxt        = 1'b1;
            w_last_grant_nxt    = r_cur_ch;
            w_seq_nxt[r_cur_ch] = r_seq[r_cur_ch] + 1'b1;
            w_beat_cnt_nxt      = '0;
            w_state_nxt         = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge fifo_rdclk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_beat_cnt   <= '0;
      r_last_grant <= 2'd3;
      r_cur_ch     <= '0;
      r_seq        <= '0;
      r_up_valid   <= 1'b0;
      r_up_sop     <= 1'b0;
      r_up_eop     <= 1'b0;
      r_up_data    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cur_ch     <= w_cur_ch_nxt;
      r_seq        <= w_seq_nxt;
      r_up_valid   <= w_up_valid_nxt;
      r_up_sop     <= w_up_sop_nxt;
      r_up_eop     <= w_up_eop_nxt;
      r_up_data    <= w_up_data_nxt;
    end
  end

  assign sched_if.ch_rdreq = w_rdreq;
  assign sched_if.up_valid = r_up_valid;
  assign sched_if.up_data  = r_up_data;
  assign sched_if.up_sop   = r_up_sop;
  assign sched_if.up_eop   = r_up_eop;
  assign sched_if.busy     = (r_state != StIdle);
  assign sched_if.cur_ch   = r_cur_ch;

endmodule

// File: tb/tb_ch_packet_scheduler.sv
// Directed bench for ch_packet_scheduler: a default-size instance (PKT_LEN 128)
// and a small one (PKT_LEN 4, SEQ_W 2), each fed by a show-ahead FIFO model.
module tb_ch_packet_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ch_packet_scheduler_if ifa ();
  ch_packet_scheduler_if ifb ();

  ch_packet_scheduler dut_a (
    .fifo_rdclk (clk),
    .rst_n      (rst_n),
    .sched_if   (ifa)
  );

  ch_packet_scheduler #(
    .PKT_LEN (4),
    .SEQ_W   (2)
  ) dut_b (
    .fifo_rdclk (clk),
    .rst_n      (rst_n),
    .sched_if   (ifb)
  );

  // FIFO model: word = {ch+1, 24'h0, read index}; used = written - read.
  logic [31:0] wr_a [4] = '{default: 32'd0};
  logic [31:0] rd_a [4] = '{default: 32'd0};
  logic [31:0] wr_b [4] = '{default: 32'd0};
  logic [31:0] rd_b [4] = '{default: 32'd0};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ifa.ch_rdreq[i]) rd_a[i] <= rd_a[i] + 32'd1;
      if (ifb.ch_rdreq[i]) rd_b[i] <= rd_b[i] + 32'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ifa.ch_q[i]       = {8'(i + 1), 24'h0, rd_a[i]};
      ifa.ch_rdusedw[i] = 13'(wr_a[i] - rd_a[i]);
      ifb.ch_q[i]       = {8'(i + 1), 24'h0, rd_b[i]};
      ifb.ch_rdusedw[i] = 13'(wr_b[i] - rd_b[i]);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] cap_data [$];
  logic        cap_sop  [$];
  logic        cap_eop  [$];
  int          cap_cyc  [$];
  int          cap_rdreq [4];
  int          cap_multi;
  int          cap_hold_err;

  task automatic clear_capture();
    cap_data.delete(); cap_sop.delete(); cap_eop.delete(); cap_cyc.delete();
    for (int i = 0; i < 4; i++) cap_rdreq[i] = 0;
    cap_multi = 0;
    cap_hold_err = 0;
  endtask

  // Records accepted words on instance A with up_ready held high.
  task automatic capture_a(input int n_words, input int budget);
    clear_capture();
    for (int c = 0; c < budget && cap_data.size() < n_words; c++) begin
      ifa.up_ready = 1'b1;
      #1;
      if (ifa.up_valid && ifa.up_ready) begin
        cap_data.push_back(ifa.up_data); cap_sop.push_back(ifa.up_sop);
        cap_eop.push_back(ifa.up_eop);   cap_cyc.push_back(c);
      end
      for (int i = 0; i < 4; i++) if (ifa.ch_rdreq[i]) cap_rdreq[i]++;
      if ($countones(ifa.ch_rdreq) > 1) cap_multi++;
      @(negedge clk);
    end
  endtask

  // Records accepted words on instance B, driving up_ready from a repeating pattern.
  task automatic capture_b(input int n_words, input int budget, input logic [7:0] pat);
    logic        pv, pr, ps, pe;
    logic [63:0] pd;
    clear_capture();
    pv = 1'b0; pr = 1'b1; ps = 1'b0; pe = 1'b0; pd = '0;
    for (int c = 0; c < budget && cap_data.size() < n_words; c++) begin
      ifb.up_ready = pat[c % 8];
      #1;
      if (pv && !pr && (!ifb.up_valid || ifb.up_data !== pd || ifb.up_sop !== ps ||
                        ifb.up_eop !== pe)) cap_hold_err++;
      if (ifb.up_valid && ifb.up_ready) begin
        cap_data.push_back(ifb.up_data); cap_sop.push_back(ifb.up_sop);
        cap_eop.push_back(ifb.up_eop);   cap_cyc.push_back(c);
      end
      for (int i = 0; i < 4; i++) if (ifb.ch_rdreq[i]) cap_rdreq[i]++;
      if ($countones(ifb.ch_rdreq) > 1) cap_multi++;
      pv = ifb.up_valid; pr = ifb.up_ready; pd = ifb.up_data;
      ps = ifb.up_sop;   pe = ifb.up_eop;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifa.ch_enable = '0; ifb.ch_enable = '0;
    ifa.up_ready = 1'b1; ifb.up_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_a[i] = rd_a[i];
      wr_b[i] = rd_b[i];
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.ch_enable = '0; ifb.ch_enable = '0;
    ifa.up_ready = 1'b0; ifb.up_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (ifa.up_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b want 0", ifa.up_valid); end
    n_checks++; if (ifa.up_sop !== 1'b0 || ifa.up_eop !== 1'b0) begin n_fail++;
      $display("FAIL reset_sop_eop: got %b%b want 00", ifa.up_sop, ifa.up_eop); end
    n_checks++; if (ifa.up_data !== 64'h0) begin n_fail++;
      $display("FAIL reset_data: got %h want 0", ifa.up_data); end
    n_checks++; if (ifa.ch_rdreq !== 4'b0000) begin n_fail++;
      $display("FAIL reset_rdreq: got %b want 0000", ifa.ch_rdreq); end
    n_checks++; if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy: got %b%b want 00", ifa.busy, ifb.busy); end
    n_checks++; if (ifa.cur_ch !== 2'd0) begin n_fail++;
      $display("FAIL reset_cur_ch: got %0d want 0", ifa.cur_ch); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_channel();
    logic [31:0] base;
    logic [63:0] exp;
    int bad_flags;
    do_reset();
    base = rd_a[0];
    wr_a[0] = rd_a[0] + 32'd128;
    ifa.ch_enable = 4'b0001;
    capture_a(129, 400);
    n_checks++; if (cap_data.size() != 129) begin n_fail++;
      $display("FAIL single_count: got %0d words want 129", cap_data.size()); end
    bad_flags = 0;
    for (int k = 0; k < cap_data.size(); k++) begin
      exp = (k == 0) ? 64'hADF90C00_0100_0000 : {8'h01, 24'h0, 32'(base + 32'(k - 1))};
      n_checks++; if (cap_data[k] !== exp) begin n_fail++;
        $display("FAIL single_word%0d: got %h want %h", k, cap_data[k], exp); end
      if (cap_sop[k] !== (k == 0) || cap_eop[k] !== (k == 128)) bad_flags++;
    end
    n_checks++; if (bad_flags != 0) begin n_fail++;
      $display("FAIL single_sop_eop: got %0d bad words want 0", bad_flags); end
    n_checks++; if (cap_rdreq[0] != 128 || cap_rdreq[1] + cap_rdreq[2] + cap_rdreq[3] != 0)
      begin n_fail++; $display("FAIL single_rdreq: got %0d/%0d/%0d/%0d want 128/0/0/0",
        cap_rdreq[0], cap_rdreq[1], cap_rdreq[2], cap_rdreq[3]); end
    n_checks++; if (cap_multi != 0) begin n_fail++;
      $display("FAIL single_onehot: got %0d multi-hot cycles want 0", cap_multi); end
    n_checks++; if ((cap_cyc.size() > 128 ? cap_cyc[128] : -1) != 130 ||
                    (cap_cyc.size() > 0 ? cap_cyc[0] : -1) != 2) begin n_fail++;
      $display("FAIL single_latency: got hdr@%0d last@%0d want 2/130",
        cap_cyc.size() > 0 ? cap_cyc[0] : -1, cap_cyc.size() > 128 ? cap_cyc[128] : -1); end
    n_checks++; if (ifa.busy !== 1'b0 || ifa.up_valid !== 1'b0) begin n_fail++;
      $display("FAIL single_idle_after: got busy=%b valid=%b want 0/0", ifa.busy, ifa.up_valid);
    end
  endtask

  task automatic test_threshold();
    logic [31:0] base;
    do_reset();
    wr_a[2] = rd_a[2] + 32'd127;
    ifa.ch_enable = 4'b0100;
    repeat (6) @(negedge clk);
    n_checks++; if (ifa.busy !== 1'b0 || ifa.up_valid !== 1'b0) begin n_fail++;
      $display("FAIL thresh_127: got busy=%b valid=%b want 0/0", ifa.busy, ifa.up_valid); end
    base = rd_a[2];
    wr_a[2] = wr_a[2] + 32'd1;
    capture_a(129, 400);
    n_checks++; if ((cap_data.size() > 0 ? cap_data[0] : 64'h0) !== 64'hADF90C00_0300_0000)
      begin n_fail++; $display("FAIL thresh_header: got %h want adf90c0003000000",
        cap_data.size() > 0 ? cap_data[0] : 64'h0); end
    n_checks++; if ((cap_cyc.size() > 0 ? cap_cyc[0] : -1) != 2) begin n_fail++;
      $display("FAIL thresh_latency: got %0d want 2", cap_cyc.size() > 0 ? cap_cyc[0] : -1); end
    n_checks++; if ((cap_data.size() > 128 ? cap_data[128] : 64'h0) !==
                    {8'h03, 24'h0, 32'(base + 32'd127)}) begin n_fail++;
      $display("FAIL thresh_last: got %h want %h", cap_data.size() > 128 ? cap_data[128] : 64'h0,
        {8'h03, 24'h0, 32'(base + 32'd127)}); end
    n_checks++; if (ifa.cur_ch !== 2'd2) begin n_fail++;
      $display("FAIL thresh_cur_ch: got %0d want 2", ifa.cur_ch); end
  endtask

  task automatic test_fairness();
    logic [31:0] base [4];
    logic [63:0] exp;
    int ch, seq, idx;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      base[i] = rd_a[i];
      wr_a[i] = rd_a[i] + 32'd300;
    end
    ifa.ch_enable = 4'b1111;
    capture_a(645, 1000);
    n_checks++; if (cap_data.size() != 645) begin n_fail++;
      $display("FAIL fair_count: got %0d words want 645", cap_data.size()); end
    for (int m = 0; m < 5; m++) begin
      ch  = (m == 4) ? 0 : m;
      seq = (m == 4) ? 1 : 0;
      idx = m * 129;
      exp = {32'hADF90C00, 8'(ch + 1), 8'h00, 16'(seq)};
      n_checks++; if ((cap_data.size() > idx ? cap_data[idx] : 64'h0) !== exp) begin n_fail++;
        $display("FAIL fair_hdr%0d: got %h want %h", m,
          cap_data.size() > idx ? cap_data[idx] : 64'h0, exp); end
      n_checks++; if ((cap_cyc.size() > idx ? cap_cyc[idx] : -1) != 2 + 130 * m) begin
        n_fail++; $display("FAIL fair_gap%0d: got cycle %0d want %0d", m,
          cap_cyc.size() > idx ? cap_cyc[idx] : -1, 2 + 130 * m); end
      exp = {8'(ch + 1), 24'h0, 32'(base[ch] + ((m == 4) ? 32'd128 : 32'd0))};
      n_checks++; if ((cap_data.size() > idx + 1 ? cap_data[idx + 1] : 64'h0) !== exp) begin
        n_fail++; $display("FAIL fair_pay%0d: got %h want %h", m,
          cap_data.size() > idx + 1 ? cap_data[idx + 1] : 64'h0, exp); end
    end
    n_checks++; if (cap_rdreq[0] != 256 || cap_rdreq[1] != 128 || cap_rdreq[2] != 128 ||
                    cap_rdreq[3] != 128 || cap_multi != 0) begin n_fail++;
      $display("FAIL fair_rdreq: got %0d/%0d/%0d/%0d multi=%0d want 256/128/128/128 multi=0",
        cap_rdreq[0], cap_rdreq[1], cap_rdreq[2], cap_rdreq[3], cap_multi); end
  endtask

  task automatic test_backpressure();
    logic [31:0] base;
    logic [63:0] exp;
    do_reset();
    base = rd_b[0];
    wr_b[0] = rd_b[0] + 32'd4;
    ifb.ch_enable = 4'b0001;
    capture_b(5, 100, 8'b0110_1001);
    n_checks++; if (cap_data.size() != 5) begin n_fail++;
      $display("FAIL bp_count: got %0d words want 5", cap_data.size()); end
    for (int k = 0; k < cap_data.size(); k++) begin
      exp = (k == 0) ? 64'hADF90C00_0100_0000 : {8'h01, 24'h0, 32'(base + 32'(k - 1))};
      n_checks++; if (cap_data[k] !== exp || cap_sop[k] !== (k == 0) || cap_eop[k] !== (k == 4))
        begin n_fail++; $display("FAIL bp_word%0d: got %h sop=%b eop=%b want %h sop=%b eop=%b",
          k, cap_data[k], cap_sop[k], cap_eop[k], exp, k == 0, k == 4); end
    end
    n_checks++; if (cap_hold_err != 0) begin n_fail++;
      $display("FAIL bp_hold: got %0d changed stalled words want 0", cap_hold_err); end
    n_checks++; if (cap_rdreq[0] != 4 || cap_multi != 0) begin n_fail++;
      $display("FAIL bp_rdreq: got %0d pulses multi=%0d want 4 multi=0", cap_rdreq[0], cap_multi);
    end
  endtask

  task automatic test_mask_wrap();
    logic [63:0] exp;
    int idx;
    do_reset();
    wr_b[0] = rd_b[0] + 32'd100;
    wr_b[1] = rd_b[1] + 32'd100;
    ifb.ch_enable = 4'b0010;
    capture_b(25, 300, 8'hFF);
    n_checks++; if (cap_data.size() != 25) begin n_fail++;
      $display("FAIL mask_count: got %0d words want 25", cap_data.size()); end
    for (int m = 0; m < 5; m++) begin
      idx = m * 5;
      exp = {32'hADF90C00, 8'h02, 8'h00, 16'(m % 4)};
      n_checks++; if ((cap_data.size() > idx ? cap_data[idx] : 64'h0) !== exp) begin n_fail++;
        $display("FAIL mask_hdr%0d: got %h want %h", m,
          cap_data.size() > idx ? cap_data[idx] : 64'h0, exp); end
    end
    n_checks++; if (cap_rdreq[0] != 0 || cap_rdreq[1] != 20) begin n_fail++;
      $display("FAIL mask_rdreq: got ch0=%0d ch1=%0d want 0/20", cap_rdreq[0], cap_rdreq[1]); end
  endtask

  task automatic test_mid_packet_reset();
    logic [31:0] base1;
    logic [63:0] seen;
    int cnt;
    logic found;
    do_reset();
    base1 = rd_a[1];
    wr_a[0] = rd_a[0] + 32'd256;
    wr_a[1] = rd_a[1] + 32'd128;
    wr_a[2] = rd_a[2] + 32'd128;
    ifa.ch_enable = 4'b0111;
    capture_a(129, 400);
    n_checks++; if ((cap_data.size() > 0 ? cap_data[0] : 64'h0) !== 64'hADF90C00_0100_0000)
      begin n_fail++; $display("FAIL mpr_first_hdr: got %h want adf90c0001000000",
        cap_data.size() > 0 ? cap_data[0] : 64'h0); end
    cnt = 0; found = 1'b0; seen = '0;
    for (int c = 0; c < 60 && !found; c++) begin
      #1;
      if (ifa.up_valid && !ifa.up_sop) begin
        if (cnt == 10) begin found = 1'b1; seen = ifa.up_data; end
        else cnt++;
      end
      if (!found) @(negedge clk);
    end
    n_checks++; if (!found || seen !== {8'h02, 24'h0, 32'(base1 + 32'd10)}) begin n_fail++;
      $display("FAIL mpr_beat10: got found=%b data=%h want found=1 data=%h", found, seen,
        {8'h02, 24'h0, 32'(base1 + 32'd10)}); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (ifa.up_valid !== 1'b0 || ifa.ch_rdreq !== 4'b0000 || ifa.busy !== 1'b0 ||
                    ifa.cur_ch !== 2'd0) begin n_fail++;
      $display("FAIL mpr_cleared: got valid=%b rdreq=%b busy=%b cur=%0d want 0/0000/0/0",
        ifa.up_valid, ifa.ch_rdreq, ifa.busy, ifa.cur_ch); end
    rst_n = 1'b1;
    capture_a(1, 20);
    n_checks++; if ((cap_data.size() > 0 ? cap_data[0] : 64'h0) !== 64'hADF90C00_0100_0000 ||
                    (cap_cyc.size() > 0 ? cap_cyc[0] : -1) != 2) begin n_fail++;
      $display("FAIL mpr_regrant: got %h at %0d want adf90c0001000000 at 2",
        cap_data.size() > 0 ? cap_data[0] : 64'h0, cap_cyc.size() > 0 ? cap_cyc[0] : -1); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.ch_enable = '0; ifb.ch_enable = '0;
    ifa.up_ready = 1'b0; ifb.up_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_channel();
    test_threshold();
    test_fairness();
    test_backpressure();
    test_mask_wrap();
    test_mid_packet_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
